uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled by a runtime clocks-per-bit value, 8N1-style framing with a
// configurable number of data bits (LSB first), one stop bit, frame-error detection and
// break handling.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-high reset
//   rx           - asynchronous serial line, idles high
//   clks_per_bit - clk cycles per bit, latched at each start-bit detection (min 2)
//   rx_data      - last good frame, held until the next good frame
//   rx_valid     - one-cycle pulse when rx_data is updated
//   frame_err    - one-cycle pulse when the stop bit is sampled low
//   busy         - high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CPB_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [CPB_WIDTH-1:0] clks_per_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CPB_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CPB_WIDTH-1:0] cpb_l_q, cpb_l_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;

  logic [CPB_WIDTH-1:0] cpb_last;
  logic [CPB_WIDTH-1:0] cyc_inc;

  assign cpb_last = cpb_l_q - CPB_WIDTH'(1);
  assign cyc_inc  = cyc_cnt_q + CPB_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    cpb_l_d     = cpb_l_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d   = StStart;
          cyc_cnt_d = '0;
          // Below 2 clocks per bit the mid-bit sample point collapses onto the edge.
          cpb_l_d   = (clks_per_bit < CPB_WIDTH'(2)) ? CPB_WIDTH'(2) : clks_per_bit;
        end
      end
      StStart: begin
        if (cyc_cnt_q == (cpb_l_q >> 1)) begin
          if (!rx_s_q) begin
            state_d   = StData;
            cyc_cnt_d = '0;
            bit_cnt_d = '0;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cyc_cnt_d = cyc_inc;
        end
      end
      StData: begin
        if (cyc_cnt_q == cpb_last) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cyc_cnt_d = '0;
          if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
            state_d   = StStop;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end else begin
          cyc_cnt_d = cyc_inc;
        end
      end
      StStop: begin
        if (cyc_cnt_q == cpb_last) begin
          cyc_cnt_d = '0;
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cyc_cnt_d = cyc_inc;
        end
      end
      StWaitHigh: begin
        // Hold off until the line is released so a break never looks like a start bit.
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      cpb_l_q     <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      cpb_l_q     <= cpb_l_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] clks_per_bit;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .DATA_BITS(8),
    .CPB_WIDTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .clks_per_bit(clks_per_bit),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         cpb;
    int         stop_low;  // >0: stop bit held low this many cycles
    int         gap;       // idle-high cycles after the frame
    int         sw_bit;    // data bit at which clks_per_bit is changed (-1: none)
    int         sw_val;
    logic       exp_err;
  } vec_t;

  exp_t       sb_q[$];
  logic [7:0] last_good = 8'h00;
  vec_t       vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (rx_valid || frame_err)) begin
      if (sb_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_pulse: valid=%b err=%b data=%h, expected no pulse",
                 rx_valid, frame_err, rx_data);
      end else begin
        e = sb_q.pop_front();
        check("pulse_is_frame_err", {31'b0, frame_err}, {31'b0, e.err});
        check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        if (rx_valid) begin
          check("busy_at_valid", {31'b0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_vec(input vec_t v);
    exp_t e;
    if (v.exp_err) begin
      e.err  = 1'b1;
      e.data = last_good;
    end else begin
      e.err     = 1'b0;
      e.data    = v.data;
      last_good = v.data;
    end
    sb_q.push_back(e);
    clks_per_bit = 4'(v.cpb);
    drive_bit(1'b0, v.cpb);
    for (int i = 0; i < 8; i++) begin
      if (i == v.sw_bit) clks_per_bit = 4'(v.sw_val);
      drive_bit(v.data[i], v.cpb);
    end
    if (v.stop_low > 0) begin
      drive_bit(1'b0, v.stop_low);
      check("busy_during_break", {31'b0, busy}, 32'd1);
      drive_bit(1'b1, 5);
      check("busy_after_break", {31'b0, busy}, 32'd0);
      drive_bit(1'b1, v.cpb);
    end else begin
      drive_bit(1'b1, v.cpb);
    end
    if (v.gap > 0) drive_bit(1'b1, v.gap);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check(name, sb_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [7:0] prev;
    logic [7:0] d55;

    vecs[0] = '{8'hA5, 10, 0,  20, -1, 0,  1'b0};
    vecs[1] = '{8'h3C, 10, 30, 20, -1, 0,  1'b1};
    vecs[2] = '{8'h00, 10, 0,  0,  -1, 0,  1'b0};
    vecs[3] = '{8'hFF, 10, 0,  0,  -1, 0,  1'b0};
    vecs[4] = '{8'h81, 10, 0,  20, -1, 0,  1'b0};
    vecs[5] = '{8'hC3, 10, 0,  20, 3,  5,  1'b0};
    vecs[6] = '{8'h6E, 5,  0,  20, -1, 0,  1'b0};
    vecs[7] = '{8'h5A, 3,  0,  10, -1, 0,  1'b0};
    vecs[8] = '{8'h96, 15, 0,  10, -1, 0,  1'b0};
    vecs[9] = '{8'h01, 4,  0,  10, -1, 0,  1'b0};

    reset        = 1'b1;
    rx           = 1'b1;
    clks_per_bit = 4'd10;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, 10);

    for (int i = 0; i < 10; i++) begin
      send_vec(vecs[i]);
    end
    drain("table_drained");

    // Short low glitch: start rejected, nothing changes.
    prev = last_good;
    clks_per_bit = 4'd10;
    drive_bit(1'b0, 3);
    check("glitch_busy", {31'b0, busy}, 32'd1);
    drive_bit(1'b1, 30);
    check("glitch_idle", {31'b0, busy}, 32'd0);
    check("glitch_rx_data", {24'b0, rx_data}, {24'b0, prev});

    // Reset during data bit 4 of 0x55, then a clean 0x12 frame.
    d55 = 8'h55;
    drive_bit(1'b0, 10);
    for (int i = 0; i < 4; i++) drive_bit(d55[i], 10);
    drive_bit(d55[4], 5);
    reset = 1'b1;
    @(negedge clk);
    last_good = 8'h00;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_rx_data", {24'b0, rx_data}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive_bit(1'b1, 20);
    check("post_reset_idle", {31'b0, busy}, 32'd0);
    v = '{8'h12, 10, 0, 20, -1, 0, 1'b0};
    send_vec(v);
    drain("final_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
